// File: rtl/dly_line_pkg.sv
// rtl/dly_line_pkg.sv - shared types and helpers for the two-channel delay line controller
package dly_line_pkg;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } dly_state_t;

    localparam logic BANK_CH1 = 1'b0;
    localparam logic BANK_CH2 = 1'b1;

    // Requested depths outside 1..max_depth are pinned to the nearest legal value.
    function automatic int clamp_depth(input int req, input int max_depth);
        if (req == 0) begin
            return 1;
        end
        if (req > max_depth) begin
            return max_depth;
        end
        return req;
    endfunction

endpackage

// File: rtl/dly_line_addr_gen.sv
// rtl/dly_line_addr_gen.sv - per-channel circular address counter with primed flag
module dly_line_addr_gen #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic [AW:0]   depth,
    input  logic          valid,
    output logic [AW-1:0] addr,
    output logic          filled
);

    localparam int DW = AW + 1;

    logic [AW:0] last;

    assign last = depth - DW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr   <= '0;
            filled <= 1'b0;
        end else if (clear) begin
            addr   <= '0;
            filled <= 1'b0;
        end else if (valid) begin
            // Completing a full lap means every slot now holds a real sample.
            if (addr == last[AW-1:0]) begin
                addr   <= '0;
                filled <= 1'b1;
            end else begin
                addr <= addr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/dly_line_ctrl.sv
// rtl/dly_line_ctrl.sv - sequencing front end for the two-channel BRAM delay line
module dly_line_ctrl
    import dly_line_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int MAX_DEPTH  = 256,
    parameter  int DEF_DEPTH1 = 16,
    parameter  int DEF_DEPTH2 = 64,
    localparam int AW         = $clog2(MAX_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [AW:0]             cfg_depth1,
    input  logic [AW:0]             cfg_depth2,
    input  logic                    cfg_load,
    input  logic                    flush_req,
    input  logic signed [WIDTH-1:0] data_in1,
    input  logic signed [WIDTH-1:0] data_in2,
    input  logic                    valid_in1,
    input  logic                    valid_in2,
    output logic                    in_ready,
    output logic                    bram_wea,
    output logic                    bram_web,
    output logic [AW:0]             bram_addra,
    output logic [AW:0]             bram_addrb,
    output logic signed [WIDTH-1:0] bram_dina,
    output logic signed [WIDTH-1:0] bram_dinb,
    output logic                    out_valid1,
    output logic                    out_valid2,
    output logic                    busy,
    output logic                    drop_err
);

    localparam int DW = AW + 1;

    dly_state_t    state, state_nx;
    logic          armed;
    logic [AW-1:0] flush_cnt, flush_cnt_nx;
    logic [AW:0]   depth1, depth2;
    logic [AW-1:0] addr1, addr2;
    logic          filled1, filled2;
    logic          acc1, acc2, clear;

    // armed keeps every port quiet for the first clock after reset release.
    assign busy     = armed && (state == ST_FLUSH);
    assign in_ready = (state == ST_RUN);
    assign acc1     = in_ready && valid_in1;
    assign acc2     = in_ready && valid_in2;

    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        case (state)
            ST_FLUSH: begin
                if (cfg_load) begin
                    flush_cnt_nx = '0;
                end else if (armed) begin
                    if (flush_cnt == AW'(MAX_DEPTH - 1)) begin
                        state_nx     = ST_RUN;
                        flush_cnt_nx = '0;
                    end else begin
                        flush_cnt_nx = flush_cnt + AW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (cfg_load || flush_req) begin
                    state_nx     = ST_FLUSH;
                    flush_cnt_nx = '0;
                end
            end
            default: begin
                state_nx     = ST_FLUSH;
                flush_cnt_nx = '0;
            end
        endcase
    end

    assign clear = (state_nx == ST_FLUSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_FLUSH;
            armed      <= 1'b0;
            flush_cnt  <= '0;
            depth1     <= DW'(DEF_DEPTH1);
            depth2     <= DW'(DEF_DEPTH2);
            out_valid1 <= 1'b0;
            out_valid2 <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            armed      <= 1'b1;
            flush_cnt  <= flush_cnt_nx;
            out_valid1 <= acc1 && filled1;
            out_valid2 <= acc2 && filled2;
            if (cfg_load) begin
                depth1   <= DW'(clamp_depth(32'(cfg_depth1), MAX_DEPTH));
                depth2   <= DW'(clamp_depth(32'(cfg_depth2), MAX_DEPTH));
                drop_err <= 1'b0;
            end
            // A sample offered while not ready is lost; setting wins over the load clear.
            if ((valid_in1 || valid_in2) && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

    dly_line_addr_gen #(.AW(AW)) u_addr_ch1 (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .depth   (depth1),
        .valid   (acc1),
        .addr    (addr1),
        .filled  (filled1)
    );

    dly_line_addr_gen #(.AW(AW)) u_addr_ch2 (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .depth   (depth2),
        .valid   (acc2),
        .addr    (addr2),
        .filled  (filled2)
    );

    assign bram_wea   = busy || acc1;
    assign bram_web   = busy || acc2;
    assign bram_addra = {BANK_CH1, busy ? flush_cnt : addr1};
    assign bram_addrb = {BANK_CH2, busy ? flush_cnt : addr2};
    assign bram_dina  = in_ready ? data_in1 : '0;
    assign bram_dinb  = in_ready ? data_in2 : '0;

endmodule

// File: tb/tb_dly_line_ctrl.sv
// tb/tb_dly_line_ctrl.sv - randomized self-checking bench for dly_line_ctrl with BRAM and delay model
module tb_dly_line_ctrl;

    localparam int W  = 32;
    localparam int MD = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW:0]   cfg_depth1 = '0, cfg_depth2 = '0;
    logic          cfg_load = 1'b0, flush_req = 1'b0;
    logic [W-1:0]  data_in1 = '0, data_in2 = '0;
    logic          valid_in1 = 1'b0, valid_in2 = 1'b0;
    logic          in_ready, bram_wea, bram_web, out_valid1, out_valid2, busy, drop_err;
    logic [AW:0]   bram_addra, bram_addrb;
    logic [W-1:0]  bram_dina, bram_dinb;

    dly_line_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_depth1 (cfg_depth1),
        .cfg_depth2 (cfg_depth2),
        .cfg_load   (cfg_load),
        .flush_req  (flush_req),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .valid_in1  (valid_in1),
        .valid_in2  (valid_in2),
        .in_ready   (in_ready),
        .bram_wea   (bram_wea),
        .bram_web   (bram_web),
        .bram_addra (bram_addra),
        .bram_addrb (bram_addrb),
        .bram_dina  (bram_dina),
        .bram_dinb  (bram_dinb),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    // Read-first dual-port BRAM with one cycle of read latency.
    logic [W-1:0] mem [0:2*MD-1];
    logic [W-1:0] douta, doutb;
    always @(posedge clk) begin
        douta <= mem[bram_addra];
        doutb <= mem[bram_addrb];
        if (bram_wea) mem[bram_addra] <= bram_dina;
        if (bram_web) mem[bram_addrb] <= bram_dinb;
    end

    int n_pass = 0;
    int n_total = 0;

    bit          m_armed, m_run, m_ov1, m_ov2, m_drop;
    int          m_fcnt, m_dep1, m_dep2;
    int unsigned m_dv1, m_dv2;
    int unsigned q1[$];
    int unsigned q2[$];

    function automatic int tb_clamp(input int req);
        return (req == 0) ? 1 : ((req > MD) ? MD : req);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_armed = 0; m_run = 0; m_fcnt = 0;
        m_dep1 = 16; m_dep2 = 64;
        m_ov1 = 0; m_ov2 = 0; m_drop = 0;
        q1.delete(); q2.delete();
    endtask

    task automatic step(input bit v1, input int unsigned d1, input bit v2, input int unsigned d2,
                        input bit cl, input bit fr);
        bit acc1, acc2, busy_m;
        busy_m = m_armed && !m_run;
        chk("busy", busy, busy_m);
        chk("in_ready", in_ready, m_run);
        chk("out_valid1", out_valid1, m_ov1);
        chk("out_valid2", out_valid2, m_ov2);
        chk("drop_err", drop_err, m_drop);
        if (m_ov1) chk("dout1", douta, m_dv1);
        if (m_ov2) chk("dout2", doutb, m_dv2);
        valid_in1 = v1; data_in1 = d1; valid_in2 = v2; data_in2 = d2;
        cfg_load = cl; flush_req = fr;
        #1;
        if (busy_m) begin
            chk("flush_port", {bram_wea, bram_web, bram_addra, bram_addrb},
                {1'b1, 1'b1, 1'b0, 8'(m_fcnt), 1'b1, 8'(m_fcnt)});
            chk("flush_din", {bram_dina, bram_dinb}, 64'h0);
        end else if (m_run) begin
            chk("run_we", {bram_wea, bram_web}, {v1, v2});
            chk("addr1", bram_addra, {1'b0, 8'(q1.size() % m_dep1)});
            chk("addr2", bram_addrb, {1'b1, 8'(q2.size() % m_dep2)});
            if (v1) chk("din1", bram_dina, d1);
            if (v2) chk("din2", bram_dinb, d2);
        end else begin
            chk("idle_we", {bram_wea, bram_web}, 2'b00);
        end
        acc1 = v1 && m_run;
        acc2 = v2 && m_run;
        m_ov1 = acc1 && (q1.size() >= m_dep1);
        m_ov2 = acc2 && (q2.size() >= m_dep2);
        if (m_ov1) m_dv1 = q1[q1.size() - m_dep1];
        if (m_ov2) m_dv2 = q2[q2.size() - m_dep2];
        if (acc1) q1.push_back(d1);
        if (acc2) q2.push_back(d2);
        if (cl) m_drop = 0;
        if ((v1 || v2) && !m_run) m_drop = 1;
        if (cl) begin
            m_dep1 = tb_clamp(int'(cfg_depth1));
            m_dep2 = tb_clamp(int'(cfg_depth2));
            m_run = 0; m_fcnt = 0; q1.delete(); q2.delete();
        end else if (fr && m_run) begin
            m_run = 0; m_fcnt = 0; q1.delete(); q2.delete();
        end else if (busy_m) begin
            if (m_fcnt == MD - 1) begin
                m_run = 1; m_fcnt = 0;
            end else begin
                m_fcnt++;
            end
        end
        m_armed = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_outs", {busy, in_ready, out_valid1, out_valid2, bram_wea, bram_web, drop_err}, 7'b0);
        valid_in1 = 0; valid_in2 = 0; cfg_load = 0; flush_req = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run_flush(input string tag, input int rnd_cycles, input int exp_busy);
        int nb;
        nb = 0;
        for (int i = 0; i < 400 && !m_run; i++) begin
            if (busy) nb++;
            if (i < rnd_cycles) step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom, 0, 0);
            else step(0, 0, 0, 0, 0, 0);
        end
        chk(tag, nb, exp_busy);
    endtask

    task automatic stream(input int n, input int p1, input int p2);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 99) < p1, $urandom, $urandom_range(0, 99) < p2, $urandom, 0, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz, first, n;
        bit v;
        for (int i = 0; i < 2 * MD; i++) mem[i] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        do_reset();

        // T1: power-up flush zeroes both banks
        run_flush("t1_busy_cycles", 0, 256);
        nz = 0;
        for (int i = 0; i < 2 * MD; i++) if (mem[i] !== '0) nz++;
        chk("t1_zero_fill", nz, 0);

        // T2: ch1 depth 16, continuous samples 1..40
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid1 && first == 0) first = i;
            step(1, i, 0, 0, 0, 0);
        end
        chk("t2_first_ov1_step", first, 18);
        stream(3, 0, 0);

        // T3: gapped ch2 depth 64
        n = 0;
        for (int i = 0; i < 800 && n < 200; i++) begin
            v = ($urandom_range(0, 2) != 0);
            if (v) n++;
            step(0, 0, v, $urandom, 0, 0);
        end
        chk("t3_samples", n, 200);
        stream(150, 60, 60);

        // T4: load depth 0 / 300 in RUN, traffic during flush
        cfg_depth1 = 9'd0;
        cfg_depth2 = 9'd300;
        step(0, 0, 0, 0, 1, 0);
        run_flush("t4_busy_cycles", 20, 256);
        chk("t4_drop_sticky", drop_err, 1'b1);
        stream(300, 100, 100);

        // T5a: cfg_load and flush_req together
        cfg_depth1 = 9'd8;
        cfg_depth2 = 9'd4;
        step(0, 0, 0, 0, 1, 1);
        chk("t5_drop_cleared", drop_err, 1'b0);
        run_flush("t5a_busy_cycles", 0, 256);
        stream(30, 100, 80);

        // T5b: flush_req ignored mid-flush, cfg_load at flush_cnt 100 restarts
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 300 && m_fcnt != 100; i++) step(0, 0, 0, 0, 0, m_fcnt == 50);
        chk("t5b_reach_100", m_fcnt, 100);
        cfg_depth1 = 9'd5;
        cfg_depth2 = 9'd3;
        step(0, 0, 0, 0, 1, 0);
        run_flush("t5b_busy_cycles", 0, 256);
        stream(40, 70, 70);

        // T6: async reset mid-RUN with a sample in flight
        valid_in1 = 1'b1;
        data_in1 = 32'h1234_5678;
        do_reset();
        run_flush("t6_busy_cycles", 0, 256);
        stream(80, 100, 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
